adc_avg_filter: RTL
===================

# adc_avg_filter

Boxcar averaging and decimation stage for the main ADC current and voltage channels. It sits directly downstream of the main ADC controller and consumes its 24-bit signed I/V samples and sample-valid strobe. It sums 2^N consecutive samples per channel and emits one rounded average per window, with a single-cycle valid strobe, to the regulation loop and the register file.

## Interface
Parameters:
- `DATA_WIDTH`, default 24: sample and average width, signed two's complement.
- `MAX_LOG2_N`, default 8: largest supported window exponent (window up to 256 samples).

Ports:
- `i_clk`, in, 1: single clock for the block.
- `i_rst`, in, 1: reset, synchronous, active-low.
- `i_enable`, in, 1: 1 runs averaging; 0 forces IDLE and clears the window.
- `i_avg_log2_n`, in, 4: window exponent N (window = 2^N samples); values above `MAX_LOG2_N` are clamped to it.
- `i_adc_data_valid`, in, 1: single-cycle strobe, one new I/V sample pair.
- `i_i_adc_data`, in, DATA_WIDTH: current sample, signed.
- `i_v_adc_data`, in, DATA_WIDTH: voltage sample, signed.
- `o_i_avg_data`, out, DATA_WIDTH: current average, signed, held until the next result.
- `o_v_avg_data`, out, DATA_WIDTH: voltage average, signed, held until the next result.
- `o_avg_valid`, out, 1: one-cycle pulse, new averages present on the outputs.
- `o_sample_cnt`, out, MAX_LOG2_N+1: samples accumulated in the current window.
- `o_state`, out, 2: 0 = IDLE, 1 = ACC.

## Operation
- Accumulators: two signed accumulators, DATA_WIDTH+MAX_LOG2_N bits each, with every sample sign-extended before it is added. They cannot overflow for any legal N.
- Window latch: N_active is latched from the clamped `i_avg_log2_n` when a window starts. A window starts on the first valid after entering ACC, and on the first valid after a window closes. Changes to `i_avg_log2_n` mid-window take effect only at the next window.
- IDLE to ACC: when `i_enable`=1. At this transition, accumulators, count and N_active are cleared or reloaded.
- ACC to IDLE: when `i_enable`=0, on any cycle. The partial window is discarded, no `o_avg_valid` is produced, and any result already in the pipeline is still delivered.
- Per valid in ACC: acc += sample and the count increments.
  - The sample that makes count = 2^N_active closes the window.
  - The closing sample is summed (acc + sample) into the snapshot registers.
  - On the same edge, the accumulators and count clear to 0.
  - The next valid, including one on the very next cycle, starts the next window. No sample is ever dropped.
- Result stage: each snapshot S gives avg = (S + 2^(N_active−1)) >>> N_active (arithmetic shift).
  - The rounding term is 0 when N_active = 0.
  - avg is saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Ties round toward +∞.
- Pass-through: N_active = 0 gives one output per input sample.
- Valid outside ACC: `i_adc_data_valid` in IDLE is ignored.

## Timing
- Reset (`i_rst`=0 at a rising edge):
  - Outputs: `o_i_avg_data`=0, `o_v_avg_data`=0, `o_avg_valid`=0, `o_sample_cnt`=0, `o_state`=IDLE.
  - Internal: all accumulators and the pipeline are cleared.
  - Reset mid-window discards everything, including any in-flight snapshot.
- Latency: closing valid at cycle t. The snapshot registers at t+1. `o_avg_valid`=1 and the averages update at t+2.
- Throughput: one valid per clock is sustained. With N=0 and back-to-back valids, `o_avg_valid` is high continuously, lagging the input by 2 cycles.
- `o_sample_cnt` is registered. It shows the count after the edge that processed a valid and returns to 0 on the closing edge.
- `i_enable` deassert and a valid on the same cycle: the valid is discarded and the state goes to IDLE.

## Test plan
- N=2, constant samples I=0x000100, V=0xFFFF00 (−256), 8 valids every 10 cycles → exactly 2 `o_avg_valid` pulses. Each pulse has I=0x000100 and V=0xFFFF00, and arrives 2 cycles after the 4th and 8th valid.
- N=1, I samples 1 then 2 (sum 3) → 0x000002 (round half up). I samples −1 then −2 (sum −3) → 0xFFFFFF (−1).
- N=8, all I=0x7FFFFF and all V=0x800000 → I=0x7FFFFF and V=0x800000. Check there is no wrap or saturation artefact.
- N=0, 5 back-to-back valids with I=1..5 → `o_avg_valid` high for 5 consecutive cycles starting 2 cycles after the first valid, with I outputs 1..5 in order.
- N=3, drop `i_enable` after 5 valids, re-enable, then 8 valids of 0x000010 → a single output of 0x000010. The 5 pre-disable samples must not contribute.
- N=2, change `i_avg_log2_n` to 4 after the 2nd valid → the first output follows the 4th valid. The next output follows 16 further valids. Reset asserted mid-window → all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/adc_avg_filter_if.sv
// adc_avg_filter_if: sample strobe/data in, averaged results and status out.
interface adc_avg_filter_if #(
    parameter int DATA_WIDTH = 24,
    parameter int MAX_LOG2_N = 8
);
    logic                  i_enable;
    logic [3:0]            i_avg_log2_n;
    logic                  i_adc_data_valid;
    logic [DATA_WIDTH-1:0] i_i_adc_data;
    logic [DATA_WIDTH-1:0] i_v_adc_data;
    logic [DATA_WIDTH-1:0] o_i_avg_data;
    logic [DATA_WIDTH-1:0] o_v_avg_data;
    logic                  o_avg_valid;
    logic [MAX_LOG2_N:0]   o_sample_cnt;
    logic [1:0]            o_state;

    modport master (
        output i_enable, i_avg_log2_n, i_adc_data_valid, i_i_adc_data, i_v_adc_data,
        input  o_i_avg_data, o_v_avg_data, o_avg_valid, o_sample_cnt, o_state
    );

    modport slave (
        input  i_enable, i_avg_log2_n, i_adc_data_valid, i_i_adc_data, i_v_adc_data,
        output o_i_avg_data, o_v_avg_data, o_avg_valid, o_sample_cnt, o_state
    );
endinterface

// File: rtl/adc_avg_filter.sv
// adc_avg_filter: boxcar average of 2^N I/V samples per window, rounded and saturated.
module adc_avg_filter #(
    parameter int DATA_WIDTH = 24,
    parameter int MAX_LOG2_N = 8
) (
    input logic             i_clk,
    input logic             i_rst,
    adc_avg_filter_if.slave bus
);
    localparam int AW = DATA_WIDTH + MAX_LOG2_N;
    localparam int CW = MAX_LOG2_N + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic signed [AW:0] SAT_MAX = {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            r_state;
    logic signed [AW-1:0]  r_acc_i, r_acc_v, r_snap_i, r_snap_v;
    logic [CW-1:0]         r_cnt;
    logic [3:0]            r_n_act, r_snap_n;
    logic                  r_snap_vld, r_avg_valid;
    logic [DATA_WIDTH-1:0] r_i_avg, r_v_avg;

    logic [3:0]            w_n_clamp, w_n_eff;
    logic signed [AW-1:0]  w_sum_i, w_sum_v;
    logic [CW-1:0]         w_cnt_inc;
    logic                  w_take, w_close;

    // Round half toward +inf, then clamp into the sample range.
    function automatic logic [DATA_WIDTH-1:0] f_round_sat(input logic signed [AW-1:0] s, input logic [3:0] n);
        logic signed [AW:0] x;
        x = {s[AW-1], s} + ((n == 4'd0) ? '0 : ({{AW{1'b0}}, 1'b1} << (n - 4'd1)));
        x = x >>> n;
        return (x > SAT_MAX) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
               (x < SAT_MIN) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : x[DATA_WIDTH-1:0];
    endfunction

    assign w_n_clamp = (bus.i_avg_log2_n > 4'(MAX_LOG2_N)) ? 4'(MAX_LOG2_N) : bus.i_avg_log2_n;
    // The first sample of a window uses the freshly latched exponent.
    assign w_n_eff   = (r_cnt == '0) ? w_n_clamp : r_n_act;
    assign w_sum_i   = r_acc_i + {{MAX_LOG2_N{bus.i_i_adc_data[DATA_WIDTH-1]}}, bus.i_i_adc_data};
    assign w_sum_v   = r_acc_v + {{MAX_LOG2_N{bus.i_v_adc_data[DATA_WIDTH-1]}}, bus.i_v_adc_data};
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_take    = bus.i_enable && (r_state == ACC) && bus.i_adc_data_valid;
    assign w_close   = w_take && (w_cnt_inc == (CW'(1) << w_n_eff));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_acc_i     <= '0;
            r_acc_v     <= '0;
            r_cnt       <= '0;
            r_n_act     <= '0;
            r_snap_i    <= '0;
            r_snap_v    <= '0;
            r_snap_n    <= '0;
            r_snap_vld  <= 1'b0;
            r_avg_valid <= 1'b0;
            r_i_avg     <= '0;
            r_v_avg     <= '0;
        end else begin
            if (!bus.i_enable || r_state == IDLE) begin
                r_state <= bus.i_enable ? ACC : IDLE;
                r_acc_i <= '0;
                r_acc_v <= '0;
                r_cnt   <= '0;
                r_n_act <= '0;
            end else if (w_take) begin
                if (r_cnt == '0)
                    r_n_act <= w_n_clamp;
                r_acc_i <= w_close ? '0 : w_sum_i;
                r_acc_v <= w_close ? '0 : w_sum_v;
                r_cnt   <= w_close ? '0 : w_cnt_inc;
            end
            // Result pipeline runs regardless of enable so in-flight results still land.
            r_snap_vld <= w_close;
            if (w_close) begin
                r_snap_i <= w_sum_i;
                r_snap_v <= w_sum_v;
                r_snap_n <= w_n_eff;
            end
            r_avg_valid <= r_snap_vld;
            if (r_snap_vld) begin
                r_i_avg <= f_round_sat(r_snap_i, r_snap_n);
                r_v_avg <= f_round_sat(r_snap_v, r_snap_n);
            end
        end
    end

    assign bus.o_i_avg_data = r_i_avg;
    assign bus.o_v_avg_data = r_v_avg;
    assign bus.o_avg_valid  = r_avg_valid;
    assign bus.o_sample_cnt = r_cnt;
    assign bus.o_state      = r_state;
endmodule
